uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer placed directly upstream of the UART transmitter. It accepts bytes from a host write port at clk rate and feeds them one at a time over the transmitter's send/data/done interface. It holds send and data stable until the transmitter's slow baud-tick logic has started the frame, then waits for frame completion before issuing the next byte. All logic runs on the system clk; the transmitter's outputs are sampled as ordinary clk-domain inputs.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
AW, $clog2(DEPTH), pointer width (derived localparam, not overridable)
ACCEPT_TIMEOUT, 4096, clk cycles allowed between send assertion and start-bit detection before an error is flagged

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
wr_en  input  1  host write strobe; one byte per cycle
wr_data  input  8  host byte
full  output  1  FIFO full; a write while full is dropped
empty  output  1  FIFO empty
overflow  output  1  sticky flag: a write was attempted while full
send  output  1  request to the transmitter
tx_data  output  8  byte presented to the transmitter; stable while send=1
tx_line  input  1  serial line from the transmitter, used to detect the start bit
donetx  input  1  transmitter frame-done flag
timeout_err  output  1  sticky flag: the transmitter did not start within ACCEPT_TIMEOUT
err_clr  input  1  clears overflow and timeout_err

Behaviour:
- Reset (rst=0, async), all outputs:
  - full=0, empty=1, overflow=0, send=0, tx_data=8'h00, timeout_err=0
  - pointers=0, count=0, FSM=IDLE
- Storage: circular buffer with wr_ptr/rd_ptr of AW bits, wrapping at DEPTH-1 -> 0. count has AW+1 bits; full = (count==DEPTH), empty = (count==0).
- Write: accepted when wr_en=1 and full=0. The data is visible to the FSM on the next cycle.
  - wr_en=1 while full: write is dropped, overflow<=1.
- Simultaneous write and pop in one cycle: count is unchanged and both pointers advance. This includes the full case, where the pop frees the slot in the same cycle, so the write is accepted and overflow is not set.
- FSM, registered:
  - IDLE: if !empty, pop into tx_data, rd_ptr++, go to REQ. Latency from the first write into an empty FIFO to send=1 is 2 clk.
  - REQ: send=1, run the timeout counter.
    - tx_line=0 seen -> send<=0, clear counter, go to BUSY.
    - counter reaches ACCEPT_TIMEOUT-1 -> timeout_err<=1, send<=0, drop the byte, go to IDLE.
  - BUSY: wait for a rising edge of donetx (registered previous-value compare) -> go to IDLE.
    - A donetx that is already high on entry does not count as an edge.
- Back-to-back bytes: the next send is asserted 2 clk after the donetx rise. The transmitter samples send on its following baud tick.
- err_clr: clears the sticky flags in the same cycle. If err_clr and a new error occur in the same cycle, set wins.
- tx_data holds its last value in IDLE; it is not cleared.
- Reset mid-frame: FIFO contents are discarded and send drops asynchronously. The transmitter finishes its frame independently.

Optional Feature:
UART_TXF_LEVEL_EN
- Defined: adds output port level [AW:0] equal to count, plus output almost_full, which is 1 when count >= DEPTH-2. Both reset to 0.
- Undefined: neither port exists and there is no extra logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with 3 bytes queued -> empty=1, send=0, count=0 immediately, with no clk edge required.
- Write 8'hA5 into an empty FIFO with the transmitter model attached -> send=1 two clk later with tx_data=8'hA5. send drops on tx_line=0, and IDLE is re-entered after donetx rises.
- Write 16 bytes 8'h00..8'h0F then one more (8'hFF) -> full=1, 8'hFF dropped, overflow=1. Serial output is 00..0F in order; err_clr -> overflow=0.
- Full FIFO, wr_en coincident with a pop -> write accepted, full stays 1, overflow stays 0.
- Hold tx_line=1 and donetx=0 -> timeout_err=1 exactly ACCEPT_TIMEOUT clk after send rises; send=0; the next byte is then issued.
- With UART_TXF_LEVEL_EN, write 14 bytes -> level=14, almost_full=1. Drain fully -> level=0, almost_full=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a send/tx_data/donetx handshake with start-bit timeout.
// Define UART_TXF_LEVEL_EN to add the level and almost_full outputs.
module uart_tx_fifo #(
   parameter int DEPTH          = 16,
   parameter int ACCEPT_TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       send,
   output logic [7:0] tx_data,
   input  logic       tx_line,
   input  logic       donetx,
   output logic       timeout_err,
   input  logic       err_clr
`ifdef UART_TXF_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level,
   output logic                   almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACCEPT_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [TW-1:0] timer;
   logic          done_prev;
   logic          pop;
   logic          push;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign pop   = (state == IDLE) && !empty;
   // A pop in the same cycle frees the slot, so a write while full is still accepted then.
   assign push  = wr_en && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (wr_en && !push) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // The timeout set inside REQ is assigned after the err_clr clear, so a new error wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         send        <= 1'b0;
         tx_data     <= 8'h00;
         timer       <= '0;
         timeout_err <= 1'b0;
         done_prev   <= 1'b0;
      end else begin
         done_prev <= donetx;
         if (err_clr) begin
            timeout_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  send    <= 1'b1;
                  timer   <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (!tx_line) begin
                  send  <= 1'b0;
                  timer <= '0;
                  state <= BUSY;
               end else if (timer == TIMER_LAST) begin
                  timeout_err <= 1'b1;
                  send        <= 1'b0;
                  timer       <= '0;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            BUSY: begin
               if (donetx && !done_prev) begin
                  state <= IDLE;
               end
            end
            default: begin
               send  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_TXF_LEVEL_EN
   assign level       = count;
   assign almost_full = (count >= (AW+1)'(DEPTH - 2));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and a randomized
// run, all checked against a behavioural transmitter model with an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 32;
   localparam int AW      = $clog2(DEPTH);

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       send;
   logic [7:0] tx_data;
   logic       tx_line;
   logic       donetx;
   logic       timeout_err;
   logic       err_clr;
`ifdef UART_TXF_LEVEL_EN
   logic [AW:0] level;
   logic        almost_full;
`endif

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       clr;
      logic       e_full;
      logic       e_empty;
      logic       e_ovf;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         cap_count = 0;
   int         written;
   int         n;
   int         k;
   logic [7:0] exp_q[$];
   vec_t       vecs[$];
   logic       hold_start = 1'b0;
   logic       hold_done = 1'b0;
   logic       early_done = 1'b0;
   logic       model_idle;
   logic [7:0] rbyte;

   uart_tx_fifo #(.DEPTH(DEPTH), .ACCEPT_TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .full(full),
      .empty(empty),
      .overflow(overflow),
      .send(send),
      .tx_data(tx_data),
      .tx_line(tx_line),
      .donetx(donetx),
      .timeout_err(timeout_err),
      .err_clr(err_clr)
`ifdef UART_TXF_LEVEL_EN
      ,
      .level(level),
      .almost_full(almost_full)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      wr_en   = v.wr;
      wr_data = v.data;
      err_clr = v.clr;
      @(negedge clk);
      wr_en   = 1'b0;
      err_clr = 1'b0;
      check_output($sformatf("vec%0d_full", idx), full, v.e_full);
      check_output($sformatf("vec%0d_empty", idx), empty, v.e_empty);
      check_output($sformatf("vec%0d_overflow", idx), overflow, v.e_ovf);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int cnt = 0;
      while (!(exp_q.size() == 0 && model_idle && empty && !send) && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      check_output("drain_done", cnt < budget, 1);
   endtask

   // Transmitter model: picks up a byte some ticks after send, runs a frame, then pulses donetx.
   initial begin : xmtr
      logic [7:0]  first;
      int unsigned delay;
      tx_line    = 1'b1;
      donetx     = 1'b0;
      model_idle = 1'b1;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && send === 1'b1 && !hold_start) begin
            model_idle = 1'b0;
            first = tx_data;
            delay = $urandom_range(0, 4);
            repeat (delay) @(negedge clk);
            check_output("send_held", send, 1);
            check_output("tx_data_held", tx_data, first);
            tx_line = 1'b0;
            if (early_done) donetx = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL serial_byte: got %0h, want none", tx_data);
            end else begin
               rbyte = exp_q.pop_front();
               if (tx_data !== rbyte) begin
                  failures++;
                  $display("[TB] FAIL serial_byte: got %0h, want %0h", tx_data, rbyte);
               end
            end
            cap_count++;
            @(negedge clk);
            check_output("send_drop", send, 0);
            @(negedge clk);
            donetx = 1'b0;
            repeat ($urandom_range(2, 5)) @(negedge clk);
            check_output("send_in_frame", send, 0);
            tx_line = 1'b1;
            while (hold_done) @(negedge clk);
            donetx = 1'b1;
            @(negedge clk);
            donetx = 1'b0;
            model_idle = 1'b1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0; hold_start = 1'b1;
      repeat (3) @(negedge clk);
      check_output("rst_empty", empty, 1);
      check_output("rst_full", full, 0);
      check_output("rst_send", send, 0);
      check_output("rst_tx_data", tx_data, 8'h00);
      check_output("rst_overflow", overflow, 0);
      check_output("rst_timeout_err", timeout_err, 0);
      rst = 1'b1;
      @(negedge clk);

      // Three bytes queued, then an asynchronous reset between clock edges.
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      check_output("pre_reset_send", send, 1);
      check_output("pre_reset_empty", empty, 0);
      #2 rst = 1'b0;
      #1;
      check_output("async_rst_empty", empty, 1);
      check_output("async_rst_send", send, 0);
      check_output("async_rst_full", full, 0);
      check_output("async_rst_tx_data", tx_data, 8'h00);
`ifdef UART_TXF_LEVEL_EN
      check_output("async_rst_level", level, 0);
      check_output("async_rst_almost_full", almost_full, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1 hold_start = 1'b0;
      @(negedge clk);

      // Single byte: send two edges after the write, held until the start bit.
      exp_q.push_back(8'hA5);
      wr_en = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0;
      check_output("a5_send_one_edge", send, 0);
      @(negedge clk);
      check_output("a5_send_two_edges", send, 1);
      check_output("a5_tx_data", tx_data, 8'hA5);
      wait_drain(200);

      // Park the transmitter mid-frame so the FIFO can be filled past full.
      @(posedge clk); #1 hold_done = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h55);
      written = cap_count;
      write_byte(8'h55);
      n = 0;
      while (cap_count == written && n < 50) begin @(negedge clk); n++; end
      check_output("busy_reached", n < 50, 1);
      repeat (2) @(negedge clk);
      check_output("busy_empty", empty, 1);

      for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 8'(i), 1'b0, (i == 15), 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         if (i < 16) exp_q.push_back(8'(i));
         apply_stimulus(vecs[i], i);
`ifdef UART_TXF_LEVEL_EN
         if (i < 16) begin
            check_output($sformatf("vec%0d_level", i), level, i + 1);
            check_output($sformatf("vec%0d_almost_full", i), almost_full, (i + 1 >= DEPTH - 2));
         end
`endif
      end

      // Release the frame and write exactly on the cycle the FSM pops while full.
      @(posedge clk); #1 hold_done = 1'b0;
      @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'hAB; exp_q.push_back(8'hAB);
      @(posedge clk); #1 wr_en = 1'b0;
      @(negedge clk);
      check_output("coincident_full", full, 1);
      check_output("coincident_overflow", overflow, 0);
      check_output("coincident_send", send, 1);
      check_output("coincident_tx_data", tx_data, 8'h00);
      wait_drain(800);
      check_output("drained_overflow", overflow, 0);
`ifdef UART_TXF_LEVEL_EN
      check_output("drained_level", level, 0);
      check_output("drained_almost_full", almost_full, 0);
`endif

      // donetx already high when BUSY is entered must not end the frame.
      @(posedge clk); #1 early_done = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'hD1);
      exp_q.push_back(8'hD2);
      write_byte(8'hD1);
      write_byte(8'hD2);
      wait_drain(200);
      @(posedge clk); #1 early_done = 1'b0;
      @(negedge clk);

      // Randomized traffic, never exceeding what the FIFO can hold.
      written = cap_count;
      for (int i = 0; i < 40; i++) begin
         n = 0;
         while ((written - cap_count) >= DEPTH - 1 && n < 500) begin @(negedge clk); n++; end
         rbyte = 8'($urandom);
         exp_q.push_back(rbyte);
         written++;
         write_byte(rbyte);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain(2000);
      check_output("random_overflow", overflow, 0);
      check_output("random_timeout_err", timeout_err, 0);

      // Transmitter never starts: first byte times out and is dropped, next byte follows.
      @(posedge clk); #1 hold_start = 1'b1;
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h3C;
      @(negedge clk);
      wr_data = 8'hC3;
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (!send && n < 20) begin @(negedge clk); n++; end
      check_output("timeout_send_seen", send, 1);
      k = 0;
      while (!timeout_err && k < 2 * TIMEOUT) begin @(negedge clk); k++; end
      check_output("timeout_latency", k, TIMEOUT);
      check_output("timeout_send_low", send, 0);
      @(negedge clk);
      check_output("after_timeout_send", send, 1);
      check_output("after_timeout_tx_data", tx_data, 8'hC3);
      check_output("timeout_sticky", timeout_err, 1);
      exp_q.push_back(8'hC3);
      @(posedge clk); #1 hold_start = 1'b0;
      wait_drain(200);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_output("timeout_err_clr", timeout_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
